// File: rtl/tick_table_builder_if.sv
// Tick table builder bus interface.
// Carries the angle-request/tick-response handshake with the tick engine and
// the table write port.
//   theta_valid_o / theta_o / theta_ready_i : angle-index request
//   dt_valid_i / dt_i                       : absolute tick response
//   we_o / waddr_o / wdata_o / mem_select_o : table write port
// master = builder side, slave = engine/memory side.
interface tick_table_builder_if #(
  parameter int unsigned TICK_W_P = 16,
  parameter int unsigned ADDR_W_P = 11
);
  logic                theta_valid_o;
  logic [11:0]         theta_o;
  logic                theta_ready_i;
  logic                dt_valid_i;
  logic [TICK_W_P-1:0] dt_i;
  logic                we_o;
  logic [ADDR_W_P-1:0] waddr_o;
  logic [TICK_W_P:0]   wdata_o;
  logic [2:0]          mem_select_o;

  modport master (
    output theta_valid_o, theta_o,
    input  theta_ready_i, dt_valid_i, dt_i,
    output we_o, waddr_o, wdata_o, mem_select_o
  );

  modport slave (
    input  theta_valid_o, theta_o,
    output theta_ready_i, dt_valid_i, dt_i,
    input  we_o, waddr_o, wdata_o, mem_select_o
  );
endinterface

// File: rtl/tick_table_builder.sv
// Tick table builder.
// On start_i, queries the tick engine for FRAME_NUMBER_P edge ticks, then
// walks every (frame, passage, line point) and writes the tick delta of each
// point into the interleaved frame tables.
// Ports:
//   clk_i, nrst_i (async, active low), start_i (ignored while busy)
//   bus (tick_table_builder_if.master): request/response and write port
//   busy_o, done_o (one-cycle pulse), underflow_o (sticky)
// Optional feature: define TTB_UNDERFLOW_SAT_EN to clamp negative deltas to
// 0 and flag underflow_o; otherwise deltas wrap and underflow_o is 0.
module tick_table_builder #(
  parameter int unsigned FRAME_COLUMNS_P = 360,
  parameter int unsigned FRAME_NUMBER_P  = 5,
  parameter int unsigned LINE_POINTS_P   = 20,
  parameter int unsigned TICK_W_P        = 16,
  parameter int unsigned ADDR_W_P        = 11
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic start_i,
  tick_table_builder_if.master bus,
  output logic busy_o,
  output logic done_o,
  output logic underflow_o
);

  localparam int unsigned PASSAGES = FRAME_COLUMNS_P / LINE_POINTS_P;
  localparam int unsigned TOTAL    = FRAME_COLUMNS_P * FRAME_NUMBER_P;
  localparam int unsigned L_W      = (LINE_POINTS_P > 1) ? $clog2(LINE_POINTS_P) : 1;
  localparam int unsigned P_W      = (PASSAGES > 1) ? $clog2(PASSAGES) : 1;

  typedef enum logic [1:0] {IDLE, EDGE, FILL, DONE} state_t;

  state_t state_q, state_d;

  logic                issue_q;
  logic                theta_valid_q;
  logic [11:0]         theta_q;
  logic                wait_dt_q;
  logic [2:0]          k_q;
  logic [2:0]          f_q;
  logic [L_W-1:0]      l_q;
  logic [P_W-1:0]      p_q;
  logic [TICK_W_P-1:0] last_q;
  logic [TICK_W_P-1:0] edge_q [8];
  logic [ADDR_W_P-1:0] wcnt_q;
  logic                we_q;
  logic [ADDR_W_P-1:0] waddr_q;
  logic [TICK_W_P:0]   wdata_q;
  logic [2:0]          sel_q;
  logic                fill_last_q;

  logic                rsp_fire;
  logic                k_last, l_last, p_last, f_last;
  logic [11:0]         theta_nxt;
  logic                first_pt;
  logic [TICK_W_P-1:0] last_term, edge_term, delta;
`ifdef TTB_UNDERFLOW_SAT_EN
  logic                delta_neg;
  logic                underflow_q;
`endif

  assign rsp_fire = wait_dt_q && bus.dt_valid_i && (state_q == EDGE || state_q == FILL);
  assign k_last   = (k_q == 3'(FRAME_NUMBER_P - 1));
  assign l_last   = (l_q == L_W'(LINE_POINTS_P - 1));
  assign p_last   = (p_q == P_W'(PASSAGES - 1));
  assign f_last   = (f_q == 3'(FRAME_NUMBER_P - 1));

  // State register
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = EDGE;
      EDGE: if (rsp_fire && k_last) state_d = FILL;
      FILL: if (we_q && fill_last_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; the write-port registers hold stale values after a build,
  // so they are masked in IDLE.
  always_comb begin
    busy_o            = (state_q != IDLE);
    done_o            = (state_q == DONE);
    bus.we_o          = we_q;
    bus.theta_valid_o = theta_valid_q;
    bus.theta_o       = '0;
    bus.waddr_o       = '0;
    bus.wdata_o       = '0;
    bus.mem_select_o  = '0;
    if (state_q != IDLE) begin
      bus.theta_o      = theta_q;
      bus.waddr_o      = waddr_q;
      bus.wdata_o      = wdata_q;
      bus.mem_select_o = sel_q;
    end
`ifdef TTB_UNDERFLOW_SAT_EN
    underflow_o = underflow_q;
`else
    underflow_o = 1'b0;
`endif
  end

  // Angle index of the next request
  always_comb begin
    theta_nxt = '0;
    if (state_q == EDGE)
      theta_nxt = 12'(TOTAL - FRAME_NUMBER_P + 32'(k_q));
    else
      theta_nxt = 12'(32'(l_q) * PASSAGES * FRAME_NUMBER_P
                      + (32'(p_q) >> 1) * FRAME_NUMBER_P + 32'(f_q));
  end

  // Delta of the point currently being answered
  always_comb begin
    first_pt  = (l_q == '0) && (p_q == '0);
    last_term = first_pt ? '0 : last_q;
    edge_term = ((l_q == '0) && (p_q != '0)) ? edge_q[f_q] : '0;
`ifdef TTB_UNDERFLOW_SAT_EN
    // Sign of the true delta without widening the subtraction
    delta_neg = (({1'b0, bus.dt_i} + {1'b0, edge_term}) < {1'b0, last_term});
    delta     = delta_neg ? '0 : (bus.dt_i - last_term + edge_term);
`else
    delta     = bus.dt_i - last_term + edge_term;
`endif
  end

  // Datapath
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      issue_q       <= 1'b0;
      theta_valid_q <= 1'b0;
      theta_q       <= '0;
      wait_dt_q     <= 1'b0;
      k_q           <= '0;
      f_q           <= '0;
      l_q           <= '0;
      p_q           <= '0;
      last_q        <= '0;
      wcnt_q        <= '0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      sel_q         <= '0;
      fill_last_q   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) edge_q[i] <= '0;
`ifdef TTB_UNDERFLOW_SAT_EN
      underflow_q   <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;

      if (state_q == IDLE && start_i) begin
        issue_q     <= 1'b1;
        k_q         <= '0;
        wcnt_q      <= '0;
        fill_last_q <= 1'b0;
`ifdef TTB_UNDERFLOW_SAT_EN
        underflow_q <= 1'b0;
`endif
      end

      if (issue_q) begin
        issue_q       <= 1'b0;
        theta_valid_q <= 1'b1;
        theta_q       <= theta_nxt;
      end

      if (theta_valid_q && bus.theta_ready_i) begin
        theta_valid_q <= 1'b0;
        wait_dt_q     <= 1'b1;
      end

      if (rsp_fire) begin
        wait_dt_q <= 1'b0;
        if (state_q == EDGE) begin
          edge_q[k_q] <= bus.dt_i;
          issue_q     <= 1'b1;
          if (k_last) begin
            l_q    <= '0;
            p_q    <= '0;
            f_q    <= '0;
            last_q <= '0;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end else begin
          we_q    <= 1'b1;
          waddr_q <= wcnt_q;
          wdata_q <= {1'b1, delta};
          sel_q   <= f_q;
          last_q  <= bus.dt_i;
          if (wcnt_q == ADDR_W_P'(FRAME_COLUMNS_P - 1)) wcnt_q <= '0;
          else                                          wcnt_q <= wcnt_q + ADDR_W_P'(1);
          // l innermost, then p, then f
          if (l_last) begin
            l_q <= '0;
            if (p_last) begin
              p_q <= '0;
              f_q <= f_q + 3'd1;
            end else begin
              p_q <= p_q + P_W'(1);
            end
          end else begin
            l_q <= l_q + L_W'(1);
          end
          if (l_last && p_last && f_last) fill_last_q <= 1'b1;
          else                            issue_q     <= 1'b1;
`ifdef TTB_UNDERFLOW_SAT_EN
          if (delta_neg) underflow_q <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_table_builder.sv
module tb_tick_table_builder;

  logic clk_i   = 1'b0;
  logic nrst_i  = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o, underflow_o;

  always #5 clk_i = ~clk_i;

  tick_table_builder_if #(.TICK_W_P(16), .ADDR_W_P(11)) bus ();

  tick_table_builder #(
    .FRAME_COLUMNS_P(4),
    .FRAME_NUMBER_P (2),
    .LINE_POINTS_P  (2),
    .TICK_W_P       (16),
    .ADDR_W_P       (11)
  ) dut (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .start_i    (start_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .underflow_o(underflow_o)
  );

  int tests = 0;
  int fails = 0;

  // Hand-computed expectations for engine dt = 100*theta + 10
  int unsigned exp_theta [10] = '{6, 7, 0, 4, 0, 4, 1, 5, 1, 5};
  int unsigned exp_norm  [8]  = '{10, 400, 210, 400, 110, 400, 310, 400};
  // Engine returning 5 for theta 4/5 (the l=1 points)
`ifdef TTB_UNDERFLOW_SAT_EN
  int unsigned exp_uf    [8]  = '{10, 0, 615, 0, 110, 0, 815, 0};
  logic        exp_uf_flag    = 1'b1;
`else
  int unsigned exp_uf    [8]  = '{10, 65531, 615, 65531, 110, 65431, 815, 65431};
  logic        exp_uf_flag    = 1'b0;
`endif

  // Engine / monitor state
  int          cyc = 0, wr_n = 0, req_n = 0, done_n = 0, done_cyc = 0, last_wr_cyc = 0;
  logic [10:0] wr_addr [16];
  logic [2:0]  wr_sel  [16];
  logic [16:0] wr_data [16];
  logic [11:0] th_log  [16];
  bit          pend = 0;
  logic [11:0] ptheta = '0;
  bit          uf_mode = 0;
  bit          stall_en = 0;
  int          stall_idx = 0, stall_n = 0, stall_bad = 0, stall_we = 0;
  bit          spur_done = 0;
  logic [11:0] stall_theta = '0;

  function automatic logic [15:0] eng_dt(input logic [11:0] th);
    if (uf_mode && (th == 12'd4 || th == 12'd5)) return 16'd5;
    return 16'(32'(th) * 100 + 10);
  endfunction

  // Tick engine model and write/done monitor, all on the falling edge
  initial begin
    bus.theta_ready_i = 1'b1;
    bus.dt_valid_i    = 1'b0;
    bus.dt_i          = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!nrst_i) begin
        pend              = 0;
        bus.dt_valid_i    = 1'b0;
        bus.theta_ready_i = 1'b1;
      end else begin
        if (bus.we_o) begin
          if (wr_n < 16) begin
            wr_addr[wr_n] = bus.waddr_o;
            wr_sel[wr_n]  = bus.mem_select_o;
            wr_data[wr_n] = bus.wdata_o;
          end
          wr_n++;
          last_wr_cyc = cyc;
        end
        if (done_o) begin
          done_n++;
          done_cyc = cyc;
        end
        bus.dt_valid_i = 1'b0;
        if (pend) begin
          bus.dt_valid_i = 1'b1;
          bus.dt_i       = eng_dt(ptheta);
          pend           = 0;
        end
        if (bus.theta_valid_o) begin
          if (stall_en && req_n == stall_idx && stall_n < 5) begin
            bus.theta_ready_i = 1'b0;
            if (stall_n == 0) stall_theta = bus.theta_o;
            else if (bus.theta_o !== stall_theta) stall_bad++;
            if (bus.we_o) stall_we++;
            if (stall_n == 2 && !bus.dt_valid_i) begin
              bus.dt_valid_i = 1'b1;
              bus.dt_i       = 16'h7777;
              spur_done      = 1;
            end
            stall_n++;
          end else begin
            bus.theta_ready_i = 1'b1;
            if (req_n < 16) th_log[req_n] = bus.theta_o;
            req_n++;
            pend   = 1;
            ptheta = bus.theta_o;
          end
        end else begin
          bus.theta_ready_i = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_n = 0; req_n = 0; done_n = 0;
    stall_n = 0; stall_bad = 0; stall_we = 0; spur_done = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_i);
      if (done_n > 0) ok = 1;
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic run_build(output bit ok);
    clear_logs();
    pulse_start();
    wait_done(300, ok);
  endtask

  task automatic test_reset();
    nrst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", done_o); end
    tests++; if (underflow_o !== 1'b0) begin fails++; $display("FAIL rst_underflow: got %b expected 0", underflow_o); end
    tests++; if (bus.we_o !== 1'b0) begin fails++; $display("FAIL rst_we: got %b expected 0", bus.we_o); end
    tests++; if (bus.theta_valid_o !== 1'b0) begin fails++; $display("FAIL rst_theta_valid: got %b expected 0", bus.theta_valid_o); end
    tests++; if (bus.theta_o !== 12'd0) begin fails++; $display("FAIL rst_theta: got %0d expected 0", bus.theta_o); end
    tests++; if (bus.waddr_o !== 11'd0) begin fails++; $display("FAIL rst_waddr: got %0d expected 0", bus.waddr_o); end
    tests++; if (bus.wdata_o !== 17'd0) begin fails++; $display("FAIL rst_wdata: got %0d expected 0", bus.wdata_o); end
    tests++; if (bus.mem_select_o !== 3'd0) begin fails++; $display("FAIL rst_sel: got %0d expected 0", bus.mem_select_o); end
    nrst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic check_writes(input string tag, input bit uf);
    int unsigned e;
    tests++; if (wr_n !== 8) begin fails++; $display("FAIL %s_wr_count: got %0d expected 8", tag, wr_n); end
    for (int i = 0; i < 8 && i < wr_n; i++) begin
      e = uf ? exp_uf[i] : exp_norm[i];
      tests++;
      if (wr_addr[i] !== 11'(i % 4) || wr_sel[i] !== 3'(i / 4) || wr_data[i] !== {1'b1, 16'(e)}) begin
        fails++;
        $display("FAIL %s_write%0d: got addr %0d sel %0d data 0x%0h expected addr %0d sel %0d data 0x%0h",
                 tag, i, wr_addr[i], wr_sel[i], wr_data[i], i % 4, i / 4, {1'b1, 16'(e)});
      end
    end
  endtask

  task automatic check_thetas(input string tag);
    tests++; if (req_n !== 10) begin fails++; $display("FAIL %s_req_count: got %0d expected 10", tag, req_n); end
    for (int i = 0; i < 10 && i < req_n; i++) begin
      tests++;
      if (th_log[i] !== 12'(exp_theta[i])) begin
        fails++;
        $display("FAIL %s_theta%0d: got %0d expected %0d", tag, i, th_log[i], exp_theta[i]);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    run_build(ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_timeout: got no done expected done"); end
    check_thetas("basic");
    check_writes("basic", 0);
    tests++; if (done_n !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_n); end
    tests++; if (done_cyc !== last_wr_cyc + 1) begin fails++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_wr_cyc + 1); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL basic_idle_busy: got %b expected 0", busy_o); end
    tests++; if (bus.waddr_o !== 11'd0 || bus.wdata_o !== 17'd0 || bus.mem_select_o !== 3'd0 || bus.theta_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_outputs: got waddr %0d wdata %0d sel %0d tv %b expected all 0",
               bus.waddr_o, bus.wdata_o, bus.mem_select_o, bus.theta_valid_o);
    end
    tests++; if (underflow_o !== 1'b0) begin fails++; $display("FAIL basic_underflow: got %b expected 0", underflow_o); end
  endtask

  task automatic test_stall_spurious();
    bit ok;
    stall_en = 1; stall_idx = 2;
    run_build(ok);
    stall_en = 0;
    tests++; if (!ok) begin fails++; $display("FAIL stall_done_timeout: got no done expected done"); end
    tests++; if (stall_n !== 5) begin fails++; $display("FAIL stall_window: got %0d cycles expected 5", stall_n); end
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL stall_theta_stable: got %0d changes expected 0", stall_bad); end
    tests++; if (stall_theta !== 12'd0) begin fails++; $display("FAIL stall_theta: got %0d expected 0", stall_theta); end
    tests++; if (stall_we !== 0) begin fails++; $display("FAIL stall_we: got %0d writes expected 0", stall_we); end
    tests++; if (spur_done !== 1'b1) begin fails++; $display("FAIL stall_spurious_injected: got %b expected 1", spur_done); end
    check_thetas("stall");
    check_writes("stall", 0);
  endtask

  task automatic test_underflow();
    bit ok;
    uf_mode = 1;
    run_build(ok);
    uf_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL uf_done_timeout: got no done expected done"); end
    check_writes("uf", 1);
    tests++; if (underflow_o !== exp_uf_flag) begin fails++; $display("FAIL uf_flag: got %b expected %b", underflow_o, exp_uf_flag); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    pulse_start();
    repeat (2) @(negedge clk_i);
    tests++; if (underflow_o !== 1'b0) begin fails++; $display("FAIL b2b_underflow_clear: got %b expected 0", underflow_o); end
    repeat (8) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_done_timeout: got no done expected done"); end
    repeat (20) @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %b expected 0", busy_o); end
    tests++; if (done_n !== 1) begin fails++; $display("FAIL b2b_done_count: got %0d expected 1", done_n); end
    check_thetas("b2b");
    check_writes("b2b", 0);
  endtask

  task automatic test_reset_midfill();
    bit ok;
    int wr_at_rst;
    clear_logs();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_i);
      if (wr_n >= 3) ok = 1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL mid_three_writes: got %0d writes expected 3", wr_n); end
    nrst_i = 1'b0;
    #1;
    wr_at_rst = wr_n;
    tests++; if (wr_at_rst !== 3) begin fails++; $display("FAIL mid_writes_at_reset: got %0d expected 3", wr_at_rst); end
    tests++; if (busy_o !== 1'b0 || done_o !== 1'b0 || underflow_o !== 1'b0 || bus.we_o !== 1'b0 ||
                bus.theta_valid_o !== 1'b0 || bus.theta_o !== 12'd0 || bus.waddr_o !== 11'd0 ||
                bus.wdata_o !== 17'd0 || bus.mem_select_o !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got busy %b done %b uf %b we %b tv %b theta %0d waddr %0d wdata %0d sel %0d expected all 0",
               busy_o, done_o, underflow_o, bus.we_o, bus.theta_valid_o, bus.theta_o,
               bus.waddr_o, bus.wdata_o, bus.mem_select_o);
    end
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (30) @(negedge clk_i);
    tests++; if (wr_n !== wr_at_rst) begin fails++; $display("FAIL mid_no_writes_after: got %0d writes expected %0d", wr_n, wr_at_rst); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL mid_busy_after: got %b expected 0", busy_o); end
    run_build(ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_rebuild_timeout: got no done expected done"); end
    check_writes("mid_rebuild", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_spurious();
    test_underflow();
    test_back_to_back();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
